tri_motion_sequencer: RTL and testbench

Frame-synchronous motion controller for the centre-screen triangle renderer. It watches the horizontal and vertical counters and sequences the triangle's centre coordinates. In free-run mode it steps the centre every N frames; in stop mode it steps once per request handshake. All coordinate updates happen inside vertical blanking, so the pixel datapath never tears mid-frame. It sits between the `horizontal_counter`/`vertical_counter` pair and the triangle compare logic, and replaces that logic's constant `CENTER_X`/`CENTER_Y`.

---
 rtl/tri_motion_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_tri_motion_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tri_motion_sequencer.sv
// tri_motion_sequencer
// Frame-synchronous motion controller for the centre-screen triangle.
// Watches the pixel counters and steps the triangle centre once every
// FRAMES_PER_STEP frames (run=1), or once per step_req/step_ack handshake
// (run=0). Coordinate updates happen only in the cycle after the first
// vertical-blanking line is detected, so no frame is drawn with a
// half-updated centre.
//
// Optional feature macro: TRI_MOTION_WRAP_EN
//   defined   -> centre wraps to the opposite limit, dir_* stay at 1
//   undefined -> centre bounces off the limits and reverses direction
module tri_motion_sequencer #(
    parameter int unsigned V_DISPLAY_END   = 511,
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned STEP_X          = 2,
    parameter int unsigned STEP_Y          = 1,
    parameter int unsigned X_MIN           = 75,
    parameter int unsigned X_MAX           = 565,
    parameter int unsigned Y_MIN           = 50,
    parameter int unsigned Y_MAX           = 430
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic [15:0] H_Count_Value,
    input  logic [15:0] V_Count_Value,
    input  logic        run,
    input  logic        step_req,
    output logic        step_ack,
    output logic [10:0] center_x,
    output logic [9:0]  center_y,
    output logic        dir_x,
    output logic        dir_y,
    output logic        frame_tick
);

    localparam logic [10:0] X_RST    = 11'((X_MIN + X_MAX) / 2);
    localparam logic [9:0]  Y_RST    = 10'((Y_MIN + Y_MAX) / 2);
    localparam logic [7:0]  CNT_LAST = 8'(FRAMES_PER_STEP - 1);

    typedef enum logic [2:0] {
        STOP,
        RUN,
        MOVE_R,
        MOVE_S,
        ACK
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] frame_cnt;
    logic       blank;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       do_step;
    logic       ack_set;
    logic       ack_clr;

    // Next centre coordinate along one axis; all compares in 12 bits so
    // neither pos+step nor lo+step can overflow the coordinate width.
    function automatic logic [11:0] next_pos(input logic [11:0] pos,
                                             input logic        dir,
                                             input logic [11:0] step,
                                             input logic [11:0] lo,
                                             input logic [11:0] hi);
`ifdef TRI_MOTION_WRAP_EN
        if (dir) return (pos + step > hi) ? lo : pos + step;
        else     return (pos < lo + step) ? hi : pos - step;
`else
        if (dir) return (pos + step >= hi) ? hi : pos + step;
        else     return (pos <= lo + step) ? lo : pos - step;
`endif
    endfunction

    // Direction after a bounce step: flips exactly when the limit is reached.
    function automatic logic next_dir(input logic [11:0] pos,
                                      input logic        dir,
                                      input logic [11:0] step,
                                      input logic [11:0] lo,
                                      input logic [11:0] hi);
        if (dir) return !(pos + step >= hi);
        else     return (pos <= lo + step);
    endfunction

    assign blank = (H_Count_Value == 16'd0) &&
                   (V_Count_Value == 16'(V_DISPLAY_END));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) state <= STOP;
        else     state <= state_next;
    end

    // Next-state and control decode.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        do_step    = 1'b0;
        ack_set    = 1'b0;
        ack_clr    = 1'b0;
        case (state)
            STOP: begin
                // run has priority over a simultaneous step request
                if (run) begin
                    state_next = RUN;
                end else if (blank && step_req && !step_ack) begin
                    state_next = MOVE_S;
                end
            end
            RUN: begin
                if (!run) begin
                    state_next = STOP;
                    cnt_clr    = 1'b1;
                end else if (blank) begin
                    if (frame_cnt == CNT_LAST) begin
                        state_next = MOVE_R;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            MOVE_R: begin
                do_step    = 1'b1;
                state_next = run ? RUN : STOP;
            end
            MOVE_S: begin
                do_step    = 1'b1;
                ack_set    = 1'b1;
                state_next = ACK;
            end
            ACK: begin
                // run is not looked at here: a rising run waits for ACK exit
                if (!step_req) begin
                    ack_clr    = 1'b1;
                    state_next = STOP;
                end
            end
            default: state_next = STOP;
        endcase
    end

    // One-cycle pulse in the cycle after blank detect, in every state.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) frame_tick <= 1'b0;
        else     frame_tick <= blank;
    end

    // Frames elapsed since the last automatic step.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst)          frame_cnt <= '0;
        else if (cnt_clr) frame_cnt <= '0;
        else if (cnt_inc) frame_cnt <= frame_cnt + 8'd1;
    end

    // Single-step acknowledge: rises with the step, falls when step_req drops.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst)          step_ack <= 1'b0;
        else if (ack_set) step_ack <= 1'b1;
        else if (ack_clr) step_ack <= 1'b0;
    end

    // Centre position and direction, updated only in a MOVE state.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            center_x <= X_RST;
            center_y <= Y_RST;
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
        end else if (do_step) begin
            center_x <= 11'(next_pos({1'b0, center_x}, dir_x, 12'(STEP_X),
                                     12'(X_MIN), 12'(X_MAX)));
            center_y <= 10'(next_pos({2'b0, center_y}, dir_y, 12'(STEP_Y),
                                     12'(Y_MIN), 12'(Y_MAX)));
`ifdef TRI_MOTION_WRAP_EN
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
`else
            dir_x    <= next_dir({1'b0, center_x}, dir_x, 12'(STEP_X),
                                 12'(X_MIN), 12'(X_MAX));
            dir_y    <= next_dir({2'b0, center_y}, dir_y, 12'(STEP_Y),
                                 12'(Y_MIN), 12'(Y_MAX));
`endif
        end
    end

endmodule

// File: tb/tb_tri_motion_sequencer.sv
// Directed testbench for tri_motion_sequencer (default parameters).
// Frames are shortened to five clocks: one blank-detect cycle (H=0, V=511)
// followed by four ordinary cycles. Outputs are sampled on the falling edge.
module tb_tri_motion_sequencer;

    logic        clk_25MHz = 1'b0;
    logic        rst;
    logic [15:0] h_count;
    logic [15:0] v_count;
    logic        run;
    logic        step_req;
    logic        step_ack;
    logic [10:0] center_x;
    logic [9:0]  center_y;
    logic        dir_x;
    logic        dir_y;
    logic        frame_tick;

    int vectors     = 0;
    int miscompares = 0;

    // Observations from the most recent frame: k1 = cycle after blank
    // detect (MOVE cycle), k2 = the cycle after that.
    logic        t_k1, a_k1, a_k2, dx_k2;
    logic [10:0] x_k1, x_k2;
    logic [9:0]  y_k2;

`ifdef TRI_MOTION_WRAP_EN
    localparam int EDGE1_X = 75;  localparam int EDGE1_DX = 1;
    localparam int EDGE2_X = 77;  localparam int EDGE2_DX = 1;
`else
    localparam int EDGE1_X = 565; localparam int EDGE1_DX = 0;
    localparam int EDGE2_X = 563; localparam int EDGE2_DX = 0;
`endif

    tri_motion_sequencer dut (
        .clk_25MHz     (clk_25MHz),
        .rst           (rst),
        .H_Count_Value (h_count),
        .V_Count_Value (v_count),
        .run           (run),
        .step_req      (step_req),
        .step_ack      (step_ack),
        .center_x      (center_x),
        .center_y      (center_y),
        .dir_x         (dir_x),
        .dir_y         (dir_y),
        .frame_tick    (frame_tick)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic frame();
        @(negedge clk_25MHz);
        h_count = 16'd0; v_count = 16'd511;
        @(negedge clk_25MHz);
        t_k1 = frame_tick; x_k1 = center_x; a_k1 = step_ack;
        h_count = 16'd5; v_count = 16'd0;
        @(negedge clk_25MHz);
        x_k2 = center_x; y_k2 = center_y; dx_k2 = dir_x; a_k2 = step_ack;
        repeat (2) @(negedge clk_25MHz);
    endtask

    task automatic pulse_reset();
        @(negedge clk_25MHz);
        rst = 1'b1;
        @(negedge clk_25MHz);
        rst = 1'b0;
        @(negedge clk_25MHz);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; step_req = 1'b0;
        h_count = 16'd5; v_count = 16'd0;
        repeat (2) @(negedge clk_25MHz);
        vectors++; if (center_x !== 11'd320) begin miscompares++; $display("FAIL reset_center_x: got %0d expected 320", center_x); end
        vectors++; if (center_y !== 10'd240) begin miscompares++; $display("FAIL reset_center_y: got %0d expected 240", center_y); end
        vectors++; if ({dir_x, dir_y} !== 2'b11) begin miscompares++; $display("FAIL reset_dir: got %b expected 11", {dir_x, dir_y}); end
        vectors++; if ({step_ack, frame_tick} !== 2'b00) begin miscompares++; $display("FAIL reset_ack_tick: got %b expected 00", {step_ack, frame_tick}); end
        rst = 1'b0;
        @(negedge clk_25MHz);
    endtask

    task automatic test_free_run();
        run = 1'b1;
        @(negedge clk_25MHz);
        frame();   // counter 0 -> 1, no step
        vectors++; if (t_k1 !== 1'b1) begin miscompares++; $display("FAIL run_tick1: got %b expected 1", t_k1); end
        vectors++; if (x_k2 !== 11'd320) begin miscompares++; $display("FAIL run_noStep1: got %0d expected 320", x_k2); end
        vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL run_tick_width: got %b expected 0", frame_tick); end
        frame();   // step
        vectors++; if (x_k1 !== 11'd320) begin miscompares++; $display("FAIL run_move_cycle_x: got %0d expected 320", x_k1); end
        vectors++; if (x_k2 !== 11'd322) begin miscompares++; $display("FAIL run_step1_x: got %0d expected 322", x_k2); end
        vectors++; if (y_k2 !== 10'd241) begin miscompares++; $display("FAIL run_step1_y: got %0d expected 241", y_k2); end
        frame();
        vectors++; if (x_k2 !== 11'd322) begin miscompares++; $display("FAIL run_noStep2: got %0d expected 322", x_k2); end
        frame();
        vectors++; if ({x_k2, y_k2} !== {11'd324, 10'd242}) begin miscompares++; $display("FAIL run_step2: got %0d,%0d expected 324,242", x_k2, y_k2); end
    endtask

    task automatic test_boundary();
        // still running from test_free_run; walk up to the right edge
        for (int i = 0; i < 300 && center_x !== 11'd564; i++) frame();
        vectors++; if (center_x !== 11'd564) begin miscompares++; $display("FAIL edge_reach: got %0d expected 564 within 300 frames", center_x); end
        vectors++; if ({center_y, dir_x} !== {10'd362, 1'b1}) begin miscompares++; $display("FAIL edge_pre: got y=%0d dx=%b expected y=362 dx=1", center_y, dir_x); end
        frame(); frame();
        vectors++; if ({x_k2, dx_k2} !== {11'(EDGE1_X), 1'(EDGE1_DX)}) begin miscompares++; $display("FAIL edge_hit: got x=%0d dx=%b expected x=%0d dx=%0d", x_k2, dx_k2, EDGE1_X, EDGE1_DX); end
        vectors++; if (y_k2 !== 10'd363) begin miscompares++; $display("FAIL edge_hit_y: got %0d expected 363", y_k2); end
        frame(); frame();
        vectors++; if ({x_k2, dx_k2} !== {11'(EDGE2_X), 1'(EDGE2_DX)}) begin miscompares++; $display("FAIL edge_after: got x=%0d dx=%b expected x=%0d dx=%0d", x_k2, dx_k2, EDGE2_X, EDGE2_DX); end
        run = 1'b0;
        repeat (2) @(negedge clk_25MHz);
    endtask

    task automatic test_single_step();
        pulse_reset();
        step_req = 1'b1;
        frame();
        vectors++; if ({a_k1, x_k1} !== {1'b0, 11'd320}) begin miscompares++; $display("FAIL ss_move_cycle: got ack=%b x=%0d expected ack=0 x=320", a_k1, x_k1); end
        vectors++; if ({a_k2, x_k2, y_k2} !== {1'b1, 11'd322, 10'd241}) begin miscompares++; $display("FAIL ss_step: got ack=%b x=%0d y=%0d expected ack=1 x=322 y=241", a_k2, x_k2, y_k2); end
        frame(); frame(); frame();   // request held: no further steps
        vectors++; if ({step_ack, center_x} !== {1'b1, 11'd322}) begin miscompares++; $display("FAIL ss_held: got ack=%b x=%0d expected ack=1 x=322", step_ack, center_x); end
        @(negedge clk_25MHz);
        step_req = 1'b0;
        vectors++; if (step_ack !== 1'b1) begin miscompares++; $display("FAIL ss_ack_before_drop: got %b expected 1", step_ack); end
        @(negedge clk_25MHz);
        vectors++; if (step_ack !== 1'b0) begin miscompares++; $display("FAIL ss_ack_fall: got %b expected 0", step_ack); end
        frame();
        vectors++; if (x_k2 !== 11'd322) begin miscompares++; $display("FAIL ss_idle: got %0d expected 322", x_k2); end
    endtask

    task automatic test_run_and_req();
        logic ack_seen;
        ack_seen = 1'b0;
        @(negedge clk_25MHz);
        run = 1'b1; step_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame();
            ack_seen = ack_seen | a_k1 | a_k2 | step_ack;
        end
        vectors++; if (ack_seen !== 1'b0) begin miscompares++; $display("FAIL both_ack: got %b expected 0", ack_seen); end
        vectors++; if ({center_x, center_y} !== {11'd326, 10'd243}) begin miscompares++; $display("FAIL both_run: got %0d,%0d expected 326,243", center_x, center_y); end
        run = 1'b0; step_req = 1'b0;
        repeat (2) @(negedge clk_25MHz);
    endtask

    task automatic test_reset_in_ack();
        step_req = 1'b1;
        frame();
        vectors++; if ({a_k2, x_k2} !== {1'b1, 11'd328}) begin miscompares++; $display("FAIL ack_entry: got ack=%b x=%0d expected ack=1 x=328", a_k2, x_k2); end
        @(negedge clk_25MHz);
        rst = 1'b1;
        #1;
        vectors++; if ({step_ack, center_x, center_y} !== {1'b0, 11'd320, 10'd240}) begin miscompares++; $display("FAIL ack_async_rst: got ack=%b x=%0d y=%0d expected ack=0 x=320 y=240", step_ack, center_x, center_y); end
        @(negedge clk_25MHz);
        rst = 1'b0; step_req = 1'b0;
        repeat (2) @(negedge clk_25MHz);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_boundary();
        test_single_step();
        test_run_and_req();
        test_reset_in_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
